countdown_timer_bank: RTL and testbench
=======================================

COUNTDOWN_TIMER_BANK -- requirements
Module: countdown_timer_bank

Interface
REQ-001 Parameters SHALL be, one per line:
  WIDTH   10  counter width per channel (>=2)
  NUM_CH  4   number of independent channels (>=1)
REQ-002 Ports SHALL be, one per line:
  clk       in   1             single clock, all logic on rising edge
  rst       in   1             synchronous reset, active-high
  start     in   NUM_CH        per-channel load/start strobe
  stop      in   NUM_CH        per-channel abort strobe
  pause     in   NUM_CH        per-channel hold level
  periodic  in   NUM_CH        mode at start: 1 = auto-reload, 0 = one-shot
  load_val  in   NUM_CH*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
  cnt       out  NUM_CH*WIDTH  current count, same packing
  busy      out  NUM_CH        channel in RUN
  done      out  NUM_CH        one-cycle expiry pulse
  any_done  out  1             OR of done
REQ-003 The design SHALL use one clock (clk); reset (rst) SHALL be synchronous and active-high.

Function
REQ-004 Each channel SHALL be an independent two-state FSM, IDLE and RUN, with registered cnt, reload (WIDTH bits) and mode (1 bit).
REQ-005 Per-channel priority at each edge SHALL be: rst > stop > start > pause > decrement.
REQ-006 stop SHALL force IDLE and cnt=0 next cycle, with no done pulse, in any state.
REQ-007 start with load_val=N>0 SHALL set cnt=N, reload=N, mode=periodic, state RUN, in any state (retrigger while running restarts, no done pulse).
REQ-008 start with load_val=0 SHALL leave state IDLE, cnt=0, and pulse done in the next cycle regardless of periodic.
REQ-009 In RUN with pause=0 and cnt>1, cnt SHALL decrement by 1 per cycle.
REQ-010 In RUN with pause=0 and cnt=1: one-shot SHALL set cnt=0 and go IDLE; periodic SHALL set cnt=reload and stay RUN; both SHALL assert done for exactly the following cycle.
REQ-011 Latency: start sampled at edge t0 with N SHALL give done high after edge t0+N; periodic repeats after t0+kN for k=2,3,... while unpaused.
REQ-012 pause=1 in RUN SHALL hold cnt and state, busy stays 1; pause at cnt=1 SHALL defer expiry, no done.
REQ-013 pause SHALL have no effect in IDLE; start SHALL load even when pause=1.
REQ-014 cnt SHALL never wrap below 0; IDLE holds cnt constant.
REQ-015 busy SHALL equal (state==RUN); done and cnt SHALL be register outputs; any_done SHALL be combinational OR of done.
REQ-016 Channels SHALL not interact; simultaneous events on different channels are handled independently.

Reset
REQ-017 rst=1 SHALL force every channel to IDLE, cnt=0, reload=0, mode=0, busy=0, done=0 at the next edge, overriding all inputs.
REQ-018 Reset mid-count SHALL cancel without a done pulse; first start after rst deasserts SHALL behave per REQ-007.

Structure
REQ-019 A shared package SHALL hold the state encoding (IDLE=0, RUN=1) and the mode constants (MODE_ONESHOT=0, MODE_PERIODIC=1).
REQ-020 One sub-module, countdown_channel (parameter WIDTH), SHALL implement a single channel; the top SHALL instantiate NUM_CH copies via generate and build any_done.

Verification
REQ-021 One-shot: ch0 start, load_val=5, periodic=0 -> cnt 5,4,3,2,1,0; done high one cycle after 5th edge; busy falls with it; no further done.
REQ-022 Periodic: ch1 start, N=3, periodic=1 -> done at t0+3, t0+6, t0+9; cnt cycles 3,2,1,3,2,1; busy stays 1 until stop, then cnt=0, no done.
REQ-023 Pause/retrigger: ch2 N=4, pause 2 cycles at cnt=1 -> cnt holds 1, done delayed 2 cycles; restart with N=6 at cnt=2 -> no done, cnt=6.
REQ-024 Edge cases: start with load_val=0 -> done next cycle, busy 0; start and stop same cycle -> IDLE, cnt 0; start with pause=1 -> cnt=N loaded.
REQ-025 Reset mid-run: ch3 N=10, rst at cnt=4 -> all outputs 0 next cycle, no done, any_done 0.
REQ-026 Parallel: all channels started same edge with N=2,3,4,5 -> done pulses on successive cycles, any_done high four consecutive cycles.

Source files
------------

// File: rtl/countdown_timer_bank_pkg.sv
// Shared definitions for the countdown timer bank.
// Holds the per-channel state encoding and the mode constants that the
// channel and top-level files import.
package countdown_timer_bank_pkg;

  // Per-channel state: IDLE = 0, RUN = 1.
  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Mode captured at start.
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/countdown_channel.sv
// Single countdown channel: two-state FSM (IDLE/RUN) with registered count,
// reload value and mode. Expiry raises done for exactly one cycle.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          load strobe (load_val, periodic sampled here)
//   stop           abort strobe, forces IDLE with cnt = 0
//   pause          hold level, only meaningful in RUN
//   periodic       1 = auto-reload on expiry, 0 = one-shot
//   load_val       start value; 0 gives an immediate done pulse
//   cnt            current count (register)
//   busy           state == RUN
//   done           one-cycle expiry pulse (register)
module countdown_channel
  import countdown_timer_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             periodic,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;

  // Priority: stop > start > pause > decrement (rst handled in the register).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    done_d   = 1'b0;

    if (stop) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (start) begin
      if (load_val == '0) begin
        // Zero-length timer expires immediately without entering RUN.
        state_d = StIdle;
        cnt_d   = '0;
        done_d  = 1'b1;
      end else begin
        state_d  = StRun;
        cnt_d    = load_val;
        reload_d = load_val;
        mode_d   = periodic ? MODE_PERIODIC : MODE_ONESHOT;
      end
    end else if (state_q == StRun && !pause) begin
      if (cnt_q > One) begin
        cnt_d = cnt_q - One;
      end else if (cnt_q == One) begin
        done_d = 1'b1;
        if (mode_q == MODE_PERIODIC) begin
          cnt_d = reload_q;
        end else begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end else begin
        // RUN with cnt = 0 is unreachable; drop back to IDLE rather than wrap.
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      reload_q <= '0;
      mode_q   <= MODE_ONESHOT;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = (state_q == StRun);
  assign done = done_q;

endmodule

// File: rtl/countdown_timer_bank.sv
// Bank of NUM_CH independent countdown timers sharing one clock and reset.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      per-channel load/start strobe
//   stop       per-channel abort strobe
//   pause      per-channel hold level
//   periodic   per-channel mode at start (1 = auto-reload)
//   load_val   channel i at bits [i*WIDTH +: WIDTH]
//   cnt        current counts, same packing as load_val
//   busy       per-channel RUN indicator
//   done       per-channel one-cycle expiry pulse
//   any_done   OR of done
module countdown_timer_bank
  import countdown_timer_bank_pkg::*;
#(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned NUM_CH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       pause,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH*WIDTH-1:0] load_val,
  output logic [NUM_CH*WIDTH-1:0] cnt,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic                    any_done
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    countdown_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .start    (start[i]),
      .stop     (stop[i]),
      .pause    (pause[i]),
      .periodic (periodic[i]),
      .load_val (load_val[i*WIDTH +: WIDTH]),
      .cnt      (cnt[i*WIDTH +: WIDTH]),
      .busy     (busy[i]),
      .done     (done[i])
    );
  end

  assign any_done = |done;

endmodule

// File: tb/tb_countdown_timer_bank.sv
// Directed self-checking bench for countdown_timer_bank.
module tb_countdown_timer_bank;

  localparam int unsigned WIDTH  = 10;
  localparam int unsigned NUM_CH = 4;

  logic                    clk;
  logic                    rst;
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       stop;
  logic [NUM_CH-1:0]       pause;
  logic [NUM_CH-1:0]       periodic;
  logic [NUM_CH*WIDTH-1:0] load_val;
  logic [NUM_CH*WIDTH-1:0] cnt;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;
  logic                    any_done;

  int checks = 0;
  int errors = 0;

  countdown_timer_bank #(
    .WIDTH  (WIDTH),
    .NUM_CH (NUM_CH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .periodic (periodic),
    .load_val (load_val),
    .cnt      (cnt),
    .busy     (busy),
    .done     (done),
    .any_done (any_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt_of(input int ch);
    return {22'd0, cnt[ch*WIDTH +: WIDTH]};
  endfunction

  task automatic set_load(input int ch, input int val);
    load_val[ch*WIDTH +: WIDTH] = WIDTH'(val);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = '0;
    stop     = '0;
    pause    = '0;
    periodic = '0;
    load_val = '0;

    // Reset state
    step();
    step();
    chk("rst_cnt", cnt, 0);
    chk("rst_busy", {28'd0, busy}, 0);
    chk("rst_done", {28'd0, done}, 0);
    chk("rst_any", {31'd0, any_done}, 0);
    rst = 1'b0;
    step();

    // One-shot ch0, N=5
    start[0] = 1'b1; set_load(0, 5); periodic[0] = 1'b0;
    step();
    start[0] = 1'b0;
    chk("os_load_cnt", cnt_of(0), 5);
    chk("os_load_busy", {31'd0, busy[0]}, 1);
    for (int v = 4; v >= 1; v--) begin
      step();
      chk("os_cnt", cnt_of(0), v);
      chk("os_nodone", {31'd0, done[0]}, 0);
    end
    step();
    chk("os_exp_cnt", cnt_of(0), 0);
    chk("os_exp_done", {31'd0, done[0]}, 1);
    chk("os_exp_any", {31'd0, any_done}, 1);
    chk("os_exp_busy", {31'd0, busy[0]}, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("os_after_done", {31'd0, done[0]}, 0);
      chk("os_after_cnt", cnt_of(0), 0);
    end

    // Periodic ch1, N=3
    start[1] = 1'b1; set_load(1, 3); periodic[1] = 1'b1;
    step();
    start[1] = 1'b0; periodic[1] = 1'b0;
    chk("per_load_cnt", cnt_of(1), 3);
    for (int p = 0; p < 3; p++) begin
      step();
      chk("per_cnt2", cnt_of(1), 2);
      chk("per_nodone2", {31'd0, done[1]}, 0);
      step();
      chk("per_cnt1", cnt_of(1), 1);
      chk("per_nodone1", {31'd0, done[1]}, 0);
      step();
      chk("per_reload", cnt_of(1), 3);
      chk("per_done", {31'd0, done[1]}, 1);
      chk("per_busy", {31'd0, busy[1]}, 1);
    end
    stop[1] = 1'b1;
    step();
    stop[1] = 1'b0;
    chk("per_stop_cnt", cnt_of(1), 0);
    chk("per_stop_busy", {31'd0, busy[1]}, 0);
    chk("per_stop_done", {31'd0, done[1]}, 0);
    step();
    chk("per_stop_done2", {31'd0, done[1]}, 0);

    // Pause and retrigger on ch2, N=4
    start[2] = 1'b1; set_load(2, 4);
    step();
    start[2] = 1'b0;
    chk("pz_load", cnt_of(2), 4);
    step(); step(); step();
    chk("pz_at1", cnt_of(2), 1);
    pause[2] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("pz_hold_cnt", cnt_of(2), 1);
      chk("pz_hold_done", {31'd0, done[2]}, 0);
      chk("pz_hold_busy", {31'd0, busy[2]}, 1);
    end
    pause[2] = 1'b0;
    step();
    chk("pz_exp_done", {31'd0, done[2]}, 1);
    chk("pz_exp_cnt", cnt_of(2), 0);
    start[2] = 1'b1; set_load(2, 4);
    step();
    start[2] = 1'b0;
    step(); step();
    chk("rt_at2", cnt_of(2), 2);
    start[2] = 1'b1; set_load(2, 6);
    step();
    start[2] = 1'b0;
    chk("rt_cnt", cnt_of(2), 6);
    chk("rt_nodone", {31'd0, done[2]}, 0);
    chk("rt_busy", {31'd0, busy[2]}, 1);
    stop[2] = 1'b1;
    step();
    stop[2] = 1'b0;
    chk("rt_stop_cnt", cnt_of(2), 0);

    // Edge cases: zero load, start+stop, start under pause
    start[0] = 1'b1; set_load(0, 0); periodic[0] = 1'b1;
    step();
    start[0] = 1'b0; periodic[0] = 1'b0;
    chk("z_done", {31'd0, done[0]}, 1);
    chk("z_busy", {31'd0, busy[0]}, 0);
    chk("z_cnt", cnt_of(0), 0);
    step();
    chk("z_done_clr", {31'd0, done[0]}, 0);
    start[1] = 1'b1; stop[1] = 1'b1; set_load(1, 7);
    step();
    start[1] = 1'b0; stop[1] = 1'b0;
    chk("ss_cnt", cnt_of(1), 0);
    chk("ss_busy", {31'd0, busy[1]}, 0);
    chk("ss_done", {31'd0, done[1]}, 0);
    start[2] = 1'b1; pause[2] = 1'b1; set_load(2, 9);
    step();
    start[2] = 1'b0;
    chk("sp_cnt", cnt_of(2), 9);
    chk("sp_busy", {31'd0, busy[2]}, 1);
    step();
    chk("sp_hold", cnt_of(2), 9);
    pause[2] = 1'b0; stop[2] = 1'b1;
    step();
    stop[2] = 1'b0;

    // Reset mid-run on ch3, N=10
    start[3] = 1'b1; set_load(3, 10);
    step();
    start[3] = 1'b0;
    chk("rm_load", cnt_of(3), 10);
    for (int i = 0; i < 6; i++) step();
    chk("rm_at4", cnt_of(3), 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rm_cnt", cnt, 0);
    chk("rm_busy", {28'd0, busy}, 0);
    chk("rm_done", {28'd0, done}, 0);
    chk("rm_any", {31'd0, any_done}, 0);
    step();
    chk("rm_done2", {28'd0, done}, 0);
    start[3] = 1'b1; set_load(3, 2);
    step();
    start[3] = 1'b0;
    chk("rm_restart", cnt_of(3), 2);
    step(); step();
    chk("rm_restart_done", {31'd0, done[3]}, 1);
    step();

    // Parallel start N=2,3,4,5
    start = '1; periodic = '0;
    set_load(0, 2); set_load(1, 3); set_load(2, 4); set_load(3, 5);
    step();
    start = '0;
    chk("par_busy", {28'd0, busy}, 4'b1111);
    step();
    chk("par_t1_done", {28'd0, done}, 0);
    chk("par_t1_any", {31'd0, any_done}, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("par_done", {28'd0, done}, 32'(1) << k);
      chk("par_any", {31'd0, any_done}, 1);
    end
    step();
    chk("par_end_done", {28'd0, done}, 0);
    chk("par_end_any", {31'd0, any_done}, 0);
    chk("par_end_busy", {28'd0, busy}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
